// File: rtl/vsq_buffer.sv
// vsq_buffer: staging buffer ahead of the VSQ quantizer.
//
// Takes LANES x DW signed accumulator vectors, clamps negative lanes to zero
// (ReLU), stores DEPTH of them, and streams each clamped vector to the
// quantizer's running-max input. After the DEPTH-th vector it pulses o_start
// and holds upstream off for DRAIN cycles while the quantizer reads the block
// back through the combinational read port.
//
// Ports:
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   i_valid/i_data  upstream vector, lane k at [k*DW +: DW]
//   o_ready         high only while filling
//   o_relu_data     registered ReLU'd vector (zero in cycles with no accept)
//   o_start         one-cycle pulse once the block is complete
//   i_rd_addr       quantizer read address
//   o_rd_data       buffer contents at i_rd_addr (combinational)

module vsq_relu_lane #(
  parameter int DW = 40
) (
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  assign q = d[DW-1] ? '0 : d;
endmodule

module vsq_buffer #(
  parameter int LANES = 16,
  parameter int DW    = 40,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DRAIN = 65
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [LANES*DW-1:0] i_data,
  output logic                o_ready,
  output logic [LANES*DW-1:0] o_relu_data,
  output logic                o_start,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [LANES*DW-1:0] o_rd_data
);
  localparam int CW = $clog2(DRAIN);

  typedef enum logic [1:0] {S_FILL, S_START, S_DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [AW-1:0]             wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]             drain_cnt, drain_cnt_nxt;
  logic [LANES-1:0][DW-1:0]  din, relu;
  logic                      accept;

  // Block storage; deliberately unreset.
  logic [LANES*DW-1:0]       mem [DEPTH];

  assign din     = i_data;
  assign o_ready = (state == S_FILL);
  assign o_start = (state == S_START);
  assign accept  = i_valid && o_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vsq_relu_lane #(.DW(DW)) u_relu (.d(din[l]), .q(relu[l]));
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    drain_cnt_nxt = drain_cnt;
    case (state)
      S_FILL: begin
        if (accept) begin
          if (wr_ptr == AW'(DEPTH-1)) begin
            wr_ptr_nxt = '0;
            state_nxt  = S_START;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      S_START: begin
        drain_cnt_nxt = '0;
        state_nxt     = S_DRAIN;
      end
      S_DRAIN: begin
        drain_cnt_nxt = drain_cnt + 1'b1;
        if (drain_cnt == CW'(DRAIN-1)) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_FILL;
      wr_ptr      <= '0;
      drain_cnt   <= '0;
      o_relu_data <= '0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      drain_cnt   <= drain_cnt_nxt;
      // Idle cycles push zero so the downstream running max is unaffected.
      o_relu_data <= accept ? relu : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_ptr] <= relu;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule
